// File: rtl/pc_sequencer.sv
// Fetch PC register and next-PC sequencing for the pipelined MIPS core.
// Ports: clk/reset, hazard stall, D-stage class flags, CP0 exc_req, mux result
//   new_pc in; pc_f, npc_sel, flush_fd, flush_all, fetch_hold out.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
  parameter int unsigned ERET_DRAIN = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_d,
  input  logic        j_d,
  input  logic        jr_d,
  input  logic        eret_d,
  input  logic        exc_req,
  input  logic [31:0] new_pc,
  output logic [31:0] pc_f,
  output logic [1:0]  npc_sel,
  output logic        flush_fd,
  output logic        flush_all,
  output logic        fetch_hold
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Counter load: DRAIN lasts ERET_DRAIN cycles, exiting when cnt hits 0.
  localparam logic [2:0] CNT_LD = 3'(ERET_DRAIN - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    npc_sel    = 2'b00;
    flush_fd   = 1'b0;
    flush_all  = 1'b0;
    fetch_hold = 1'b0;

    // Mux select: EPC while draining, else by control-flow class.
    if (state_q == DRAIN) begin
      npc_sel    = 2'b11;
      fetch_hold = 1'b1;
    end else if (jr_d) begin
      npc_sel = 2'b10;
    end else if (j_d) begin
      npc_sel = 2'b01;
    end

    if (exc_req) begin
      // Exception beats everything, including a pending eret or drain.
      pc_d      = EXC_VEC;
      state_d   = RUN;
      cnt_d     = 3'd0;
      flush_all = 1'b1;
    end else if (state_q == DRAIN) begin
      if (cnt_q != 3'd0) begin
        cnt_d = cnt_q - 3'd1;
      end else begin
        pc_d     = new_pc;
        flush_fd = 1'b1;
        state_d  = RUN;
      end
    end else if (stall) begin
      pc_d = pc_q;
    end else if (eret_d) begin
      state_d = DRAIN;
      cnt_d   = CNT_LD;
    end else if (br_d || j_d || jr_d) begin
      pc_d = new_pc;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  assign pc_f = pc_q;

endmodule
